// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake game sequencer and its surroundings
// (input decoder, obstacle block, VGA). clk/reset stay outside.
interface snake_game_ctrl_if;
    logic        start;
    logic [1:0]  dir_in;
    logic        dir_valid;
    logic        stop;
    logic [39:0] head;
    logic        inc;
    logic        move_tick;
    logic [1:0]  state;
    logic [15:0] score;

    modport master (
        output start, dir_in, dir_valid, stop,
        input  head, inc, move_tick, state, score
    );

    modport slave (
        input  start, dir_in, dir_valid, stop,
        output head, inc, move_tick, state, score
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move-tick prescaler, head stepping with wall check,
// periodic inc pulse to the obstacle block and the IDLE/PLAY/OVER game FSM.
module snake_game_ctrl #(
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned STEP      = 16,
    parameter int unsigned X_LIM     = 640,
    parameter int unsigned Y_LIM     = 480,
    parameter int unsigned START_X   = 320,
    parameter int unsigned START_Y   = 240,
    parameter int unsigned INC_EVERY = 8
) (
    input logic              clk,
    input logic              reset,
    snake_game_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_OVER = 2'b10;

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = (INC_EVERY > 1) ? $clog2(INC_EVERY) : 1;

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] XMAX_S = 11'(X_LIM - STEP);
    localparam logic signed [10:0] YMAX_S = 11'(Y_LIM - STEP);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [1:0]    dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   score_q, score_d;
    logic          inc_q, inc_d;
    logic          tick_q, tick_d;

    logic signed [10:0] nx, ny;
    logic               wall;

    // Candidate position is formed signed so a step past zero shows up negative.
    always_comb begin
        nx = signed'({1'b0, x_q});
        ny = signed'({1'b0, y_q});
        unique case (dir_q)
            D_UP:    ny = ny - STEP_S;
            D_DOWN:  ny = ny + STEP_S;
            D_LEFT:  nx = nx - STEP_S;
            default: nx = nx + STEP_S;
        endcase
        wall = (nx < 11'sd0) || (nx > XMAX_S) || (ny < 11'sd0) || (ny > YMAX_S);
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        inc_d   = 1'b0;
        tick_d  = 1'b0;

        // A reversal shares the axis bit and differs only in the sense bit.
        if (bus.dir_valid && !((bus.dir_in[1] == dir_q[1]) && (bus.dir_in[0] != dir_q[0])))
            dir_d = bus.dir_in;

        unique case (state_q)
            S_IDLE: begin
                presc_d = '0;
                if (bus.start) begin
                    state_d = S_PLAY;
                    x_d     = 10'(START_X);
                    y_d     = 10'(START_Y);
                    dir_d   = D_RIGHT;
                    score_d = '0;
                    cnt_d   = '0;
                end
            end
            S_PLAY: begin
                if (presc_q == PW'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    if (bus.stop || wall) begin
                        state_d = S_OVER;
                    end else begin
                        x_d    = nx[9:0];
                        y_d    = ny[9:0];
                        tick_d = 1'b1;
                        if (score_q != '1)
                            score_d = score_q + 16'd1;
                        if (cnt_q == CW'(INC_EVERY - 1)) begin
                            cnt_d = '0;
                            inc_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                    if (bus.stop) begin
                        state_d = S_OVER;
                        presc_d = '0;
                    end
                end
            end
            S_OVER: begin
                presc_d = '0;
                if (bus.start)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            x_q     <= 10'(START_X);
            y_q     <= 10'(START_Y);
            dir_q   <= D_RIGHT;
            cnt_q   <= '0;
            score_q <= '0;
            inc_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            inc_q   <= inc_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.head      = {x_q, y_q, x_q + 10'(STEP - 1), y_q + 10'(STEP - 1)};
    assign bus.inc       = inc_q;
    assign bus.move_tick = tick_q;
    assign bus.state     = state_q;
    assign bus.score     = score_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboarded bench for snake_game_ctrl: a game-level model predicts every
// cycle's outputs; a monitor compares them against the DUT after each edge.
module tb_snake_game_ctrl;
    localparam int TICK_DIV  = 4;
    localparam int STEP      = 16;
    localparam int X_LIM     = 640;
    localparam int Y_LIM     = 480;
    localparam int START_X   = 320;
    localparam int START_Y   = 240;
    localparam int INC_EVERY = 8;

    logic clk = 1'b0;
    logic reset;

    snake_game_ctrl_if bus ();

    snake_game_ctrl #(
        .TICK_DIV (TICK_DIV),
        .STEP     (STEP),
        .X_LIM    (X_LIM),
        .Y_LIM    (Y_LIM),
        .START_X  (START_X),
        .START_Y  (START_Y),
        .INC_EVERY(INC_EVERY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic        tick;
        logic        inc;
        logic [39:0] head;
        logic [15:0] score;
    } exp_t;

    exp_t exp_q[$];
    exp_t got;
    int   checks = 0;
    int   passed = 0;
    int   cycle  = 0;

    // Game-level model: position in pixels, direction as a unit vector.
    int DX[4] = '{0, 0, -1, 1};
    int DY[4] = '{-1, 1, 0, 0};
    int m_st, m_x, m_y, m_dir, m_ph, m_moves, m_score;

    task automatic cyc(input bit r, input bit s, input int d, input bit dv, input bit sp);
        exp_t e;
        bit   tk;
        bit   ic;
        int   nd;
        int   nx;
        int   ny;
        tk = 0;
        ic = 0;
        reset         = r;
        bus.start     = s;
        bus.dir_in    = 2'(d);
        bus.dir_valid = dv;
        bus.stop      = sp;

        nd = m_dir;
        if (dv && !(DX[d] == -DX[m_dir] && DY[d] == -DY[m_dir]))
            nd = d;

        if (r) begin
            m_st = 0; m_x = START_X; m_y = START_Y; m_dir = 3;
            m_ph = 0; m_moves = 0; m_score = 0;
        end else if (m_st == 0) begin
            m_dir = nd;
            if (s) begin
                m_st = 1; m_x = START_X; m_y = START_Y; m_dir = 3;
                m_ph = 0; m_moves = 0; m_score = 0;
            end
        end else if (m_st == 1) begin
            if (m_ph == TICK_DIV - 1) begin
                m_ph = 0;
                nx = m_x + STEP * DX[m_dir];
                ny = m_y + STEP * DY[m_dir];
                if (sp) begin
                    m_st = 2;
                end else if (nx < 0 || nx + STEP - 1 > X_LIM - 1 ||
                             ny < 0 || ny + STEP - 1 > Y_LIM - 1) begin
                    m_st = 2;
                end else begin
                    m_x = nx;
                    m_y = ny;
                    tk  = 1;
                    m_moves++;
                    if (m_score < 65535) m_score++;
                    ic = (m_moves % INC_EVERY == 0);
                end
            end else begin
                m_ph++;
                if (sp) m_st = 2;
            end
            m_dir = nd;
        end else begin
            m_dir = nd;
            if (s) m_st = 0;
        end

        e.st    = 2'(m_st);
        e.tick  = tk;
        e.inc   = ic;
        e.head  = {10'(m_x), 10'(m_y), 10'(m_x + STEP - 1), 10'(m_y + STEP - 1)};
        e.score = 16'(m_score);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a fresh output set after every rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            checks++;
            cycle++;
            if (bus.state === got.st && bus.move_tick === got.tick && bus.inc === got.inc &&
                bus.head === got.head && bus.score === got.score) begin
                passed++;
            end else begin
                $display("FAIL cycle%0d got st=%0d tick=%0d inc=%0d head=%h score=%0d exp st=%0d tick=%0d inc=%0d head=%h score=%0d",
                         cycle, bus.state, bus.move_tick, bus.inc, bus.head, bus.score,
                         got.st, got.tick, got.inc, got.head, got.score);
            end
        end
    end

    initial begin
        m_st = 0; m_x = START_X; m_y = START_Y; m_dir = 3;
        m_ph = 0; m_moves = 0; m_score = 0;

        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        idle(2);

        // Start, then run right into the east wall (first tick, inc on 8th/16th, wall).
        cyc(0, 1, 0, 0, 0);
        idle(90);

        // OVER -> IDLE -> PLAY, reversal ignored, turn up.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        idle(1);
        cyc(0, 0, 2, 1, 0);
        idle(4);
        cyc(0, 0, 0, 1, 0);
        idle(8);

        // Stop on the tick-wrap cycle.
        for (int i = 0; i < 2 * TICK_DIV && !(m_st == 1 && m_ph == TICK_DIV - 1); i++) idle(1);
        cyc(0, 0, 0, 0, 1);
        idle(3);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);

        // Reset with the prescaler at its last count.
        for (int i = 0; i < 2 * TICK_DIV && !(m_st == 1 && m_ph == TICK_DIV - 1); i++) idle(1);
        cyc(1, 0, 0, 0, 0);
        idle(2);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 399) == 0,
                $urandom_range(0, 19) == 0,
                int'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 79) == 0);
        end

        idle(2);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got %0d pending exp 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
